uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
// Return path to the host PC. Pops FIFO_RD_WIDTH-bit words from the read FIFO that
// carries DDR3 read-back data and splits each word into bytes, most significant byte
// first (the mirror of how uart_receiver packs its bytes). Each byte is serialised on
// the RS232 tx line as 8N1. One word is fetched and fully sent before the next fetch.
// PARAMETERS
// UART_BPS       9600        serial baud rate
// CLK_FREQ       50_000_000  clk frequency in Hz
// FIFO_RD_WIDTH  16          FIFO read-port width; must equal 8*FIFO_RD_BYTE
// FIFO_RD_BYTE   2           bytes per FIFO word, 1..8
// PORTS
// clk           in   1              system clock
// rst_n         in   1              asynchronous reset, active low
// fifo_rd_data  in   FIFO_RD_WIDTH  FIFO read data; valid 1 cycle after the rd_en cycle
// fifo_empty    in   1              read FIFO empty flag
// fifo_rd_en    out  1              FIFO read request, registered, 1-cycle pulse
// tx            out  1              RS232 tx line, registered, idle high
// tx_busy       out  1              high in every state except IDLE
// BEHAVIOUR
// - Clocking/reset: one clock, clk. rst_n is asynchronous and active low.
// - Reset values: tx=1, fifo_rd_en=0, tx_busy=0, state=IDLE, all counters and the word reg = 0.
// - Bit period: BIT_CNT_MAX = CLK_FREQ/UART_BPS - 1 (integer truncation); 5207 by default.
//   Every start, data and stop bit holds tx for exactly BIT_CNT_MAX+1 clk cycles.
// - FSM states: IDLE, RD, CAP, START, DATA, STOP.
//   - IDLE: if fifo_empty=0 at the edge, go to RD. fifo_rd_en=1 for the whole RD cycle.
//   - RD: for exactly one cycle, then CAP. fifo_rd_en=0 again.
//   - CAP: for exactly one cycle. Latch fifo_rd_data into the word reg, set byte_idx=FIFO_RD_BYTE-1, go to START.
//   - START: tx=0 for one bit period, then DATA with bit_idx=0.
//   - DATA: tx = word[8*byte_idx+bit_idx], so bits go out LSB first. Advance bit_idx after each
//     period. After bit 7, go to STOP.
//   - STOP: tx=1 for one bit period. Then:
//     - if byte_idx != 0: decrement byte_idx, go to START, no idle gap;
//     - else go to IDLE.
// - IDLE re-checks fifo_empty on the first IDLE cycle, so back-to-back words have a gap of
//   1 IDLE + 1 RD + 1 CAP cycle (tx high) between one stop bit and the next start bit.
// - fifo_rd_en:
//   - asserts only in RD, and RD is entered only from IDLE with fifo_empty=0, so the block
//     never reads an empty FIFO;
//   - at most one pulse per word.
// - fifo_empty and fifo_rd_data are ignored in every state except IDLE and CAP respectively.
// - Latency: fifo_empty falling in IDLE -> rd_en high 1 cycle later -> tx falls 3 cycles later.
// - Reset mid-frame: tx returns to 1 immediately (async). The word in flight is dropped, not
//   retransmitted. The FIFO entry already popped is lost.
// - tx is driven from a register, so it has no glitches.
// TESTING
// (Sim params: CLK_FREQ=1_000_000, UART_BPS=100_000, i.e. 10 cycles/bit; W=16, BYTE=2.)
// 1. Reset with FIFO empty for 100 cycles -> tx=1, fifo_rd_en=0, tx_busy=0 throughout.
// 2. Single word 16'hA55A, empty falls -> one rd_en pulse. Bytes A5 then 5A, each framed 0,LSB..MSB,1.
//    A UART monitor decodes 8'hA5, 8'h5A. The frame is 200 cycles start to end of last stop bit.
// 3. Three words queued (16'h0102, 16'h0304, 16'hFFFF) -> monitor decodes 01 02 03 04 FF FF.
//    Exactly 3 rd_en pulses. Inter-word gap is 3 tx-high cycles. No read once empty=1.
// 4. rst_n low during data bit 3 of byte 0 -> tx=1 in the same cycle, busy=0.
//    After release with FIFO empty there is no further activity.
// 5. Toggle fifo_empty and fifo_rd_data during DATA/STOP -> tx waveform unchanged vs scenario 2.
// 6. Boundary data 16'h0000 and 16'h00FF -> correct framing; stop bit is still 1 for all 10 cycles.

Source files
------------

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Return path to the host PC. Pops one FIFO_RD_WIDTH-bit word at a time from the
// read FIFO that carries DDR3 read-back data. It splits the word into bytes and
// sends the most significant byte first. Each byte goes out on the RS232 tx line
// as 8N1: a start bit, eight data bits LSB first, and a stop bit. A word is fully
// sent before the next word is fetched.
//
// Parameters
//   UART_BPS       serial baud rate
//   CLK_FREQ       clk frequency in Hz
//   FIFO_RD_WIDTH  FIFO read-port width, equal to 8*FIFO_RD_BYTE
//   FIFO_RD_BYTE   bytes per FIFO word, 1..8
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous reset, active low
//   fifo_rd_data  in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty    in   read FIFO empty flag
//   fifo_rd_en    out  FIFO read request, registered one-cycle pulse
//   tx            out  RS232 tx line, registered, idles high
//   tx_busy       out  high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module uart_transmitter #(
   parameter int UART_BPS      = 9600,
   parameter int CLK_FREQ      = 50_000_000,
   parameter int FIFO_RD_WIDTH = 16,
   parameter int FIFO_RD_BYTE  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   output logic                     tx,
   output logic                     tx_busy
);

   // Clocks per serial bit, minus one (integer truncation of the ratio).
   localparam int BIT_CNT_MAX = CLK_FREQ / UART_BPS - 1;
   localparam int CNT_W       = (BIT_CNT_MAX > 0) ? $clog2(BIT_CNT_MAX + 1) : 1;
   localparam int BYTE_W      = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CNT_MAX);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FIFO_RD_BYTE - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      START,
      DATA,
      STOP
   } state_t;

   state_t              state_reg,    state_next;
   logic [CNT_W-1:0]    bit_cnt_reg,  bit_cnt_next;
   logic [2:0]          bit_idx_reg,  bit_idx_next;
   logic [BYTE_W-1:0]   byte_idx_reg, byte_idx_next;
   logic [FIFO_RD_WIDTH-1:0] word_reg, word_next;
   logic                tx_reg,       tx_next;
   logic                rd_en_reg,    rd_en_next;

   logic                bit_done;
   logic [2:0]          bit_idx_inc;
   logic [7:0]          cur_byte;
   logic [7:0]          byte_lanes [FIFO_RD_BYTE];

   // Split the latched word into byte lanes. Lane 0 is the least significant
   // byte. Sending starts at the top lane, so byte_idx counts down.
   generate
      for (genvar gi = 0; gi < FIFO_RD_BYTE; gi++) begin : g_lane
         assign byte_lanes[gi] = word_reg[8*gi +: 8];
      end
   endgenerate

   assign cur_byte    = byte_lanes[byte_idx_reg];
   assign bit_done    = (bit_cnt_reg == CNT_LAST);
   assign bit_idx_inc = bit_idx_reg + 3'd1;

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         bit_idx_reg  <= '0;
         byte_idx_reg <= '0;
         word_reg     <= '0;
         tx_reg       <= 1'b1;
         rd_en_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         byte_idx_reg <= byte_idx_next;
         word_reg     <= word_next;
         tx_reg       <= tx_next;
         rd_en_reg    <= rd_en_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic.
   // tx_next holds the line level for the state being entered, so the
   // registered tx changes on the same edge as the state change.
   // -------------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      bit_cnt_next  = bit_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      byte_idx_next = byte_idx_reg;
      word_next     = word_reg;
      tx_next       = tx_reg;
      rd_en_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            tx_next = 1'b1;
            if (!fifo_empty) begin
               state_next = RD;
               rd_en_next = 1'b1;   // high for exactly the RD cycle
            end
         end

         // The FIFO presents data the cycle after the read strobe, so RD
         // only waits for that one cycle.
         RD: begin
            state_next = CAP;
         end

         CAP: begin
            word_next     = fifo_rd_data;
            byte_idx_next = BYTE_LAST;
            bit_cnt_next  = '0;
            bit_idx_next  = '0;
            tx_next       = 1'b0;   // start bit of the first byte
            state_next    = START;
         end

         START: begin
            if (bit_done) begin
               bit_cnt_next = '0;
               bit_idx_next = '0;
               tx_next      = cur_byte[0];
               state_next   = DATA;
            end else begin
               bit_cnt_next = bit_cnt_reg + 1'b1;
            end
         end

         DATA: begin
            if (bit_done) begin
               bit_cnt_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  tx_next    = 1'b1;  // stop bit
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx_inc;
                  tx_next      = cur_byte[bit_idx_inc];
               end
            end else begin
               bit_cnt_next = bit_cnt_reg + 1'b1;
            end
         end

         STOP: begin
            if (bit_done) begin
               bit_cnt_next = '0;
               if (byte_idx_reg != '0) begin
                  // More bytes in this word: go straight to the next start
                  // bit with no idle gap.
                  byte_idx_next = byte_idx_reg - 1'b1;
                  bit_idx_next  = '0;
                  tx_next       = 1'b0;
                  state_next    = START;
               end else begin
                  tx_next    = 1'b1;
                  state_next = IDLE;
               end
            end else begin
               bit_cnt_next = bit_cnt_reg + 1'b1;
            end
         end

         default: begin
            tx_next    = 1'b1;
            state_next = IDLE;
         end
      endcase
   end

   assign tx         = tx_reg;
   assign fifo_rd_en = rd_en_reg;
   assign tx_busy    = (state_reg != IDLE);

endmodule
